cordic_preproc: RTL and testbench

CORDIC_PREPROC -- requirements
Module: cordic_preproc

---
 rtl/cordic_pkg.sv | 32 +++
 rtl/cordic_quadrant.sv | 30 +++
 rtl/cordic_preproc.sv | 146 ++++++++++++++
 tb/tb_cordic_preproc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC pre-processor: FSM states,
// flag bit positions inside the infor word and the angle-reduction constants.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        QUAD   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit positions inside infor = {add180, neg_sin, neg_cos, swap}
    localparam int FLAG_SWAP    = 0;
    localparam int FLAG_NEG_COS = 1;
    localparam int FLAG_NEG_SIN = 2;
    localparam int FLAG_ADD180  = 3;

    localparam int DEG360 = 360;

    // Number of conditional-subtract steps needed to fold any operand into 0..359
    function automatic int iter_of(input int width);
        return width - 8;
    endfunction

    // Smallest multiple of 360 that lifts the most negative operand to >= 0
    function automatic int offs_of(input int width);
        int half;
        half = 1 << (width - 1);
        return ((half + DEG360 - 1) / DEG360) * DEG360;
    endfunction

endpackage

// File: rtl/cordic_quadrant.sv
// Combinational quadrant classifier: splits a 0..359 degree angle into its
// quadrant fix-up flags and the residual 0..89 degree angle.
module cordic_quadrant
    import cordic_pkg::*;
(
    input  logic [8:0] acc,
    output logic [6:0] residual,
    output logic [3:0] flags
);

    // Compare against the quadrant boundaries and strip whole quadrants off the angle
    always_comb begin
        residual = acc[6:0];
        flags    = '0;
        if (acc >= 9'd270) begin
            residual              = 7'(acc - 9'd270);
            flags[FLAG_SWAP]      = 1'b1;
            flags[FLAG_NEG_SIN]   = 1'b1;
        end else if (acc >= 9'd180) begin
            residual              = 7'(acc - 9'd180);
            flags[FLAG_NEG_COS]   = 1'b1;
            flags[FLAG_NEG_SIN]   = 1'b1;
        end else if (acc >= 9'd90) begin
            residual              = 7'(acc - 9'd90);
            flags[FLAG_SWAP]      = 1'b1;
            flags[FLAG_NEG_COS]   = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_preproc.sv
// CORDIC front-end pre-processor. Rotation requests are folded into 0..359
// degrees by a bit-serial conditional subtract, then into 0..89 plus fix-up
// flags. Vectoring requests are mirrored into the right half-plane in one edge.
module cordic_preproc
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int X_INIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_angle,
    input  logic [WIDTH-1:0] another,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] out_angle,
    output logic [3:0]       infor,
    output logic [3:0]       out_select
);

    localparam int               ITER    = iter_of(WIDTH);
    localparam int               OFFS    = offs_of(WIDTH);
    localparam int               KW      = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [KW-1:0]    K_START = KW'(ITER - 1);
    localparam logic [WIDTH:0]   OFFS_W  = (WIDTH + 1)'(OFFS);
    localparam logic [WIDTH:0]   DEG_W   = (WIDTH + 1)'(DEG360);
    localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH - 1){1'b1}}};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH:0]   acc;
    logic [KW-1:0]    k;
    logic             accept;
    logic             vec_mode;
    logic             in_neg;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   load_val;
    logic [WIDTH-1:0] vec_x;
    logic [WIDTH-1:0] vec_y;
    logic [3:0]       vec_flags;
    logic [3:0]       quad_flags;
    logic [6:0]       quad_res;

    // Two's complement negate that clamps the most negative value to the most positive
    function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
        if (v == SMIN) begin
            return SMAX;
        end
        return '0 - v;
    endfunction

    assign accept    = in_valid & in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign vec_mode  = select[3];
    assign in_neg    = in_angle[WIDTH-1];
    assign step      = DEG_W << k;
    assign load_val  = {in_angle[WIDTH-1], in_angle} + (in_neg ? OFFS_W : '0);
    assign vec_x     = in_neg ? sat_neg(in_angle) : in_angle;
    assign vec_y     = in_neg ? sat_neg(another) : another;

    // Vectoring only ever raises add180, and only for a left-half-plane x operand
    always_comb begin
        vec_flags              = '0;
        vec_flags[FLAG_ADD180] = in_neg;
    end

    cordic_quadrant u_quadrant (
        .acc      (acc[8:0]),
        .residual (quad_res),
        .flags    (quad_flags)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: rotation walks REDUCE then QUAD, vectoring jumps straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = vec_mode ? DONE : REDUCE;
            REDUCE:  if (k == '0) state_nxt = QUAD;
            QUAD:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, fold the angle while reducing, publish results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            k          <= '0;
            x          <= '0;
            y          <= '0;
            out_angle  <= '0;
            infor      <= '0;
            out_select <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_select <= select;
                        if (vec_mode) begin
                            x         <= vec_x;
                            y         <= vec_y;
                            out_angle <= '0;
                            infor     <= vec_flags;
                        end else begin
                            acc <= load_val;
                            k   <= K_START;
                        end
                    end
                end
                REDUCE: begin
                    if (acc >= step) begin
                        acc <= acc - step;
                    end
                    if (k != '0) begin
                        k <= k - KW'(1);
                    end
                end
                QUAD: begin
                    out_angle <= {{(WIDTH - 7){1'b0}}, quad_res};
                    infor     <= quad_flags;
                    x         <= WIDTH'(X_INIT);
                    y         <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_preproc.sv
// Scoreboard bench for cordic_preproc: the driver pushes the expected result
// of every accepted request, the monitor compares whenever out_valid is high.
module tb_cordic_preproc;

    localparam int W    = 16;
    localparam int ITER = W - 8;
    localparam int XI   = 1;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ang;
        logic [3:0]  infor;
        logic [3:0]  sel;
        int          lat;
        int          acc_edge;
    } exp_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_angle  = '0;
    logic [W-1:0] another   = '0;
    logic [3:0]   select    = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] out_angle;
    logic [3:0]   infor;
    logic [3:0]   out_select;

    int   checks     = 0;
    int   errors     = 0;
    int   edge_cnt   = 0;
    int   stall_left = 0;
    int   drain_n    = 0;
    bit   waiting_first = 1'b1;
    exp_t sb[$];
    exp_t cur;

    int          dir_a[18];
    int          dir_b[18];
    logic [3:0]  dir_s[18];
    logic [3:0]  r_sel;
    logic signed [15:0] r_a;
    logic signed [15:0] r_b;

    cordic_preproc #(.WIDTH(W), .X_INIT(XI)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_angle   (in_angle),
        .another    (another),
        .select     (select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x          (x),
        .y          (y),
        .out_angle  (out_angle),
        .infor      (infor),
        .out_select (out_select)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, required 'h%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour: plain modular arithmetic for rotation, mirroring for vectoring
    function automatic exp_t model(input int a, input int b, input logic [3:0] sel, input int acc_edge);
        exp_t       e;
        logic [3:0] qf[4];
        int         r;
        int         q;
        qf         = '{4'b0000, 4'b0011, 4'b0110, 4'b0101};
        e.sel      = sel;
        e.acc_edge = acc_edge;
        e.ang      = '0;
        if (sel[3]) begin
            e.lat = 1;
            if (a < 0) begin
                e.x     = (a == -32768) ? 16'h7fff : 16'(-a);
                e.y     = (b == -32768) ? 16'h7fff : 16'(-b);
                e.infor = 4'b1000;
            end else begin
                e.x     = 16'(a);
                e.y     = 16'(b);
                e.infor = 4'b0000;
            end
        end else begin
            r = a % 360;
            if (r < 0) r += 360;
            q       = r / 90;
            e.ang   = 16'(r - 90 * q);
            e.infor = qf[q];
            e.x     = 16'(XI);
            e.y     = '0;
            e.lat   = ITER + 2;
        end
        return e;
    endfunction

    task automatic applyStimulus(input int a, input int b, input logic [3:0] sel);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_angle = a[15:0];
        another  = b[15:0];
        select   = sel;
        in_valid = 1'b1;
        sb.push_back(model(a, b, sel, edge_cnt + 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_angle = 16'($urandom);
        another  = 16'($urandom);
        select   = 4'($urandom);
    endtask

    // Monitor: compare the head of the scoreboard every valid cycle, then decide consumption
    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_valid: got out_valid=1, required 0 with nothing pending");
            end else begin
                cur = sb[0];
                if (waiting_first) begin
                    checkOutput("latency", 32'(edge_cnt - cur.acc_edge + 1), 32'(cur.lat));
                    waiting_first = 1'b0;
                end
                checkOutput("x",          32'(x),          32'(cur.x));
                checkOutput("y",          32'(y),          32'(cur.y));
                checkOutput("out_angle",  32'(out_angle),  32'(cur.ang));
                checkOutput("infor",      32'(infor),      32'(cur.infor));
                checkOutput("out_select", 32'(out_select), 32'(cur.sel));
                checkOutput("busy_ready", 32'(in_ready),   32'd0);
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_ready && sb.size() > 0) begin
                void'(sb.pop_front());
                waiting_first = 1'b1;
            end
        end else begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        dir_a = '{30, 450, -90, -32768, 359, 360, 32767, -1, 0, 89, 90, 180, 270,
                  -100, -32768, 123, -5, 0};
        dir_b = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  50, 7, -45, -32768, 100};
        dir_s = '{4'b0010, 4'b0100, 4'b0111, 4'b0001, 4'b0011, 4'b0000, 4'b0101,
                  4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0111,
                  4'b1000, 4'b1011, 4'b1110, 4'b1001, 4'b1000};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
        checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("rst_x",          32'(x),          32'd0);
        checkOutput("rst_y",          32'(y),          32'd0);
        checkOutput("rst_out_angle",  32'(out_angle),  32'd0);
        checkOutput("rst_infor",      32'(infor),      32'd0);
        checkOutput("rst_out_select", 32'(out_select), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);

        // First request is held in DONE for five cycles by the consumer
        stall_left = 5;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(dir_a[i], dir_b[i], dir_s[i]);
        end

        // Reset arriving while the reduction is in progress
        applyStimulus(1000, 0, 4'b0110);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("midrst_out_valid",  32'(out_valid),  32'd0);
        checkOutput("midrst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("midrst_x",          32'(x),          32'd0);
        checkOutput("midrst_y",          32'(y),          32'd0);
        checkOutput("midrst_out_angle",  32'(out_angle),  32'd0);
        checkOutput("midrst_infor",      32'(infor),      32'd0);
        checkOutput("midrst_out_select", 32'(out_select), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_release_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_release_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 300; i++) begin
            r_sel = 4'($urandom);
            r_a   = 16'($urandom);
            r_b   = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                r_a = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7fff;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(int'(r_a), int'(r_b), r_sel);
        end

        drain_n = 0;
        while ((sb.size() != 0 || out_valid === 1'b1) && drain_n < 200) begin
            @(negedge clk);
            drain_n++;
        end
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
